// File: rtl/tile_frame_writer.sv
// Sweeps 768 tile colours into the framebuffer write port once per frame_start; first tile one cycle after frame_start.
// Object loads stall (obj_ready low) only in the frame_start cycle, when shadow is copied into active.
module tile_frame_writer #(
    parameter int          NUM_OBJ  = 4,
    parameter int          TILES_X  = 32,
    parameter int          TILES_Y  = 24,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic                       obj_valid,
    output logic                       obj_ready,
    input  logic [$clog2(NUM_OBJ)-1:0] obj_idx,
    input  logic [4:0]                 obj_x,
    input  logic [4:0]                 obj_y,
    input  logic [5:0]                 obj_w,
    input  logic [5:0]                 obj_h,
    input  logic [7:0]                 obj_color,
    output logic [9:0]                 addrWrite,
    output logic [7:0]                 dataWrite,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);
    localparam int         CW        = $clog2(TILES_X);
    localparam int         RW        = $clog2(TILES_Y);
    localparam logic [9:0] LAST_ADDR = 10'(TILES_X * TILES_Y - 1);

    typedef enum logic {IDLE, SWEEP} state_t;
    state_t state, state_next;

    logic          start, step, finish, ovr;
    logic [CW-1:0] col, sel_col, next_col;
    logic [RW-1:0] row, sel_row, next_row;
    logic [9:0]    tile_addr;
    logic [7:0]    pix;
    logic [6:0]    c7, r7;

    logic [4:0] sh_x [NUM_OBJ], sh_y [NUM_OBJ], ac_x [NUM_OBJ], ac_y [NUM_OBJ], lk_x [NUM_OBJ], lk_y [NUM_OBJ];
    logic [5:0] sh_w [NUM_OBJ], sh_h [NUM_OBJ], ac_w [NUM_OBJ], ac_h [NUM_OBJ], lk_w [NUM_OBJ], lk_h [NUM_OBJ];
    logic [7:0] sh_c [NUM_OBJ], ac_c [NUM_OBJ], lk_c [NUM_OBJ];

    assign obj_ready = ~frame_start;
    assign busy      = (state == SWEEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        ovr        = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    start      = 1'b1;
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (frame_start) begin
                    start = 1'b1;
                    ovr   = 1'b1;
                end else if (addrWrite == LAST_ADDR) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first tile is emitted on the copy edge, so it must be coloured from shadow, not active.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            lk_x[i] = frame_start ? sh_x[i] : ac_x[i];
            lk_y[i] = frame_start ? sh_y[i] : ac_y[i];
            lk_w[i] = frame_start ? sh_w[i] : ac_w[i];
            lk_h[i] = frame_start ? sh_h[i] : ac_h[i];
            lk_c[i] = frame_start ? sh_c[i] : ac_c[i];
        end
    end

    always_comb begin
        sel_col   = frame_start ? '0 : col;
        sel_row   = frame_start ? '0 : row;
        tile_addr = 10'(sel_row * TILES_X + sel_col);
        c7        = 7'(sel_col);
        r7        = 7'(sel_row);
        next_col  = sel_col + 1'b1;
        next_row  = sel_row;
        if (sel_col == CW'(TILES_X - 1)) begin
            next_col = '0;
            next_row = (sel_row == RW'(TILES_Y - 1)) ? '0 : sel_row + 1'b1;
        end
        // Walk from lowest priority up so slot 0 overrides; 7-bit sums clip instead of wrapping.
        pix = BG_COLOR;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (lk_w[i] != 6'd0 && lk_h[i] != 6'd0 &&
                {2'b00, lk_x[i]} <= c7 && c7 < {2'b00, lk_x[i]} + {1'b0, lk_w[i]} &&
                {2'b00, lk_y[i]} <= r7 && r7 < {2'b00, lk_y[i]} + {1'b0, lk_h[i]})
                pix = lk_c[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            addrWrite  <= '0;
            dataWrite  <= BG_COLOR;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= finish;
            overrun    <= ovr;
            if (start || step) begin
                addrWrite <= tile_addr;
                dataWrite <= pix;
                col       <= next_col;
                row       <= next_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_x[i] <= '0; sh_y[i] <= '0; sh_w[i] <= '0; sh_h[i] <= '0; sh_c[i] <= '0;
                ac_x[i] <= '0; ac_y[i] <= '0; ac_w[i] <= '0; ac_h[i] <= '0; ac_c[i] <= '0;
            end
        end else begin
            if (obj_valid && obj_ready) begin
                sh_x[obj_idx] <= obj_x;
                sh_y[obj_idx] <= obj_y;
                sh_w[obj_idx] <= obj_w;
                sh_h[obj_idx] <= obj_h;
                sh_c[obj_idx] <= obj_color;
            end
            if (frame_start) begin
                ac_x <= sh_x;
                ac_y <= sh_y;
                ac_w <= sh_w;
                ac_h <= sh_h;
                ac_c <= sh_c;
            end
        end
    end
endmodule

// File: doc/tile_frame_writer.md
# tile_frame_writer

- Write-side producer for the ping-pong tile framebuffer.
- Each frame it fills the current write buffer with one 8-bit colour per 20×20-pixel tile: 32 columns × 24 rows, 768 tiles, tile address = row*32 + col.
- Colours come from a small table of rectangular objects, in tile units, loaded by game logic through a valid/ready port; uncovered tiles get the background colour.
- Sits between game logic and the framebuffer controller's `addrWrite`/`dataWrite` inputs, and sweeps once per buffer swap.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of object slots; slot 0 has highest draw priority.
- `TILES_X`, 32: tiles per row.
- `TILES_Y`, 24: tile rows.
- `BG_COLOR`, 8'h00: colour of tiles covered by no enabled object.

Ports:
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse; high when the framebuffer swaps buffers (read position h==0, v==0).
- `obj_valid`  in  1  object-load request.
- `obj_ready`  out  1  object-load accept.
- `obj_idx`  in  $clog2(NUM_OBJ)  slot to load.
- `obj_x`, `obj_y`  in  5 each  top-left tile column / row.
- `obj_w`, `obj_h`  in  6 each  size in tiles; 0 means the object is invisible.
- `obj_color`  in  8  fill colour.
- `addrWrite`  out  10  tile address to the framebuffer write port.
- `dataWrite`  out  8  tile colour to the framebuffer write port.
- `busy`  out  1  high while sweeping.
- `frame_done`  out  1  one-cycle pulse when a sweep completes.
- `overrun`  out  1  one-cycle pulse when `frame_start` arrives mid-sweep.

## Operation
Object table buffering:
- Two copies of the table: shadow and active.
- A load handshake (`obj_valid && obj_ready`) writes the five fields into `shadow[obj_idx]`.
- On a `frame_start` cycle, shadow is copied whole into active. Display is therefore updated atomically per frame, with no tearing.
- `obj_ready` = ~`frame_start`: loads are refused in the copy cycle and must be held by the producer until accepted.
- Reset clears all shadow and active entries to w=h=0.

FSM states IDLE, SWEEP:
- IDLE → SWEEP on `frame_start`: col=0, row=0.
- In SWEEP, one tile is written per cycle, col incrementing and wrapping at TILES_X-1 into row+1.
- After col=TILES_X-1 with row=TILES_Y-1, return to IDLE and pulse `frame_done`.
- `frame_start` while in SWEEP: pulse `overrun`, recopy the table, restart at col=0, row=0. Stay in SWEEP; no `frame_done` for the aborted sweep.

Colour selection (combinational on col/row, using the active table):
- Object i covers the tile iff w≠0, h≠0, x ≤ col < x+w and y ≤ row < y+h.
- Sums are 7-bit, so objects extending past the edges clip with no wrap-around.
- The lowest-index covering object wins; otherwise BG_COLOR.

Write port behaviour:
- The framebuffer writes its write buffer every cycle, so outputs are registered and held stable in IDLE (last address and last data repeated).
- Rewriting the held value is harmless: that buffer is fully overwritten by the next sweep.

## Timing
- Reset values: `addrWrite`=0, `dataWrite`=BG_COLOR, `busy`=0, `frame_done`=0, `overrun`=0, state IDLE, col=row=0. `obj_ready` follows ~`frame_start` combinationally.
- `frame_start` high in cycle t → `busy` high from t+1 to t+768 inclusive.
- `addrWrite`=k and `dataWrite`=colour(tile k) are valid in cycle t+1+k, for k=0..767.
- `frame_done` high in cycle t+769; `busy` low at t+769.
- The active table used is the one copied at cycle t, so a load accepted at t-1 is visible in the frame.
- Loads accepted at t+1 or later take effect at the next `frame_start`.
- Sweep length is 768 cycles, far less than one frame, so `overrun` must never fire in normal VGA operation.
- Reset mid-sweep: outputs go to reset values immediately (asynchronous); the next `frame_start` starts a clean sweep.

## Test plan
- **Empty table:** reset, one `frame_start` → 768 writes, addresses 0..767 in consecutive cycles, all data 8'h00; `frame_done` exactly at t+769.
- **Single object:** load slot 1 with x=2, y=1, w=3, h=2, colour 8'hE0, then `frame_start` → addresses 34,35,36,66,67,68 carry 8'hE0; all others carry BG.
- **Priority and clipping:** slot 0 x=30,y=23,w=5,h=5,colour 8'h1C; slot 1 covers the whole screen with 8'h03 → addresses 766,767 = 8'h1C, all others 8'h03, no wrap into column 0 or row 0.
- **Load during sweep:** a load during the sweep changes nothing in the current sweep; the change appears in the next sweep. A load in the `frame_start` cycle sees `obj_ready`=0, is held by the producer, and is accepted the following cycle.
- **Overrun:** `frame_start` again at t+100 → `overrun` pulse at t+101, addresses restart at 0 at t+101, single `frame_done` at t+869.
- **Async reset mid-sweep:** deassert `rst_n` at t+300 → `busy`=0 and `addrWrite`=0 with no clock edge; the next `frame_start` sweeps 0..767 correctly.
